target_arm_ctrl: RTL and testbench
==================================

# target_arm_ctrl

Arming and trigger sequencer that sits directly upstream of the per-microphone `target_counter` instances. It synchronises and glitch-filters the raw active-low microphone inputs and generates each counter's `start`, the shared `stop` and the shared `clear`. It also closes a shot when every channel has fired or a timeout expires, and reports shot status to the host-facing logic.

## Interface
Parameters:
- `N_CH`, 4: number of microphone channels / downstream counters.
- `SYNC_STAGES`, 2: synchroniser flops per mic input (min 2).
- `FILT_LEN`, 3: consecutive active synchronised samples required to accept a trigger (min 1).
- `TIMEOUT_CYC`, 65535: cycles from the first accepted trigger to the forced close of the shot.

Ports:
- `clk`  in  1  system clock.
- `clr`  in  1  reset; asynchronous, active-high.
- `arm`  in  1  single-cycle host request to clear the counters and arm for a shot.
- `abort`  in  1  single-cycle host request to abandon the current shot.
- `mic_n`  in  N_CH  raw microphone comparators; asynchronous, active-low.
- `start`  out  N_CH  per-channel counter start.
- `stop`  out  1  shared counter stop.
- `ctr_clear`  out  1  shared counter clear pulse.
- `busy`  out  1  high in CLEAR, ARMED and RUN.
- `done`  out  1  high in DONE.
- `fired`  out  N_CH  sticky mask of accepted channels for the current shot.
- `timed_out`  out  1  shot closed by timeout rather than by all channels firing.

## Operation
- **Reset:** state IDLE. `start`, `stop`, `ctr_clear`, `done`, `busy`, `fired`, `timed_out`, the timeout counter and all sync/filter flops are 0.
- **Per-channel front end:**
  - Invert `mic_n`, then pass through SYNC_STAGES flops.
  - A saturating run-length counter (width clog2(FILT_LEN+1)) increments on an active sample and resets to 0 on an inactive sample.
  - `hit[i]` is high while the counter equals FILT_LEN.
- **State machine (one-hot or enum):**
  - **IDLE:** `arm` → CLEAR.
  - **CLEAR:**
    - Assert `ctr_clear` for exactly one cycle.
    - Zero `fired`, `timed_out` and the timeout counter.
    - Go to ARMED on the next cycle.
  - **ARMED:**
    - Any `hit[i]` sets `fired[i]` and moves to RUN.
    - Several channels hitting in the same cycle all set.
  - **RUN:**
    - `fired |= hit` each cycle. The timeout counter increments each cycle.
    - If `fired` is all ones, including bits set this cycle, go to DONE with `timed_out`=0.
    - Otherwise, if the counter reaches TIMEOUT_CYC-1, go to DONE with `timed_out`=1.
    - All-fired wins over timeout when both occur in the same cycle.
  - **DONE:** hold results. `arm` → CLEAR; any other input is ignored.
  - **abort:** in CLEAR, ARMED or RUN, go to DONE with `timed_out`=1 and `fired` unchanged. Ignored in IDLE and DONE.
  - **arm:** ignored in CLEAR, ARMED and RUN.
- **Outputs (all registered):**
  - `start[i]` = `fired[i]` while in RUN; 0 in every other state.
  - `stop` = 1 while in DONE, so counters halt. The downstream counter gives start priority over stop, so `start` must be low whenever `stop` is high; this block guarantees it.
  - `busy` = state ∈ {CLEAR, ARMED, RUN}.
  - `done` = state == DONE.
- **Transition cycle:** the channel that caused ARMED→RUN has `start` high in the first RUN cycle. A channel whose hit causes RUN→DONE never sees `start`; its counter stays 0 by design, as the last arrival.
- **`clr` mid-shot:** immediate return to the reset values. Because `clr` also clears the counters, no stale counts remain.

## Timing
- **Mic to `hit`:** a `mic_n` low held stable, first sampled at edge k, gives `hit` high after edge k+SYNC_STAGES+FILT_LEN-1.
- **`hit` to `start`:** `start` rises one edge after `hit`.
- **Glitch rejection:** a glitch shorter than FILT_LEN samples after sync is never accepted.
- **Arm sequence:** `arm` at edge n → `ctr_clear` high during cycle n+1 → ARMED from n+2.
- **Timeout:** the shot closes exactly TIMEOUT_CYC cycles after entry to RUN; `stop` rises on that cycle.
- **Counter width:** the timeout counter is clog2(TIMEOUT_CYC) bits and never wraps; it is reset on CLEAR.

## Structure
- Package `target_pkg`:
  - state enum `arm_state_t` {IDLE, CLEAR, ARMED, RUN, DONE};
  - default constants `N_CH_DEF`, `FILT_LEN_DEF`, `TIMEOUT_DEF`.
- Sub-module `mic_filter`: one instance per channel (generate loop). Contains the synchroniser and the run-length filter; ports `clk`, `clr`, `mic_n`, `hit`.
- The top level holds the FSM, the `fired` mask, the timeout counter and the output registers.

## Test plan
Bench settings: N_CH=4, SYNC_STAGES=2, FILT_LEN=3, TIMEOUT_CYC=100.
- **Normal shot:** `arm`, then mics 0,2,1,3 go low at 10-cycle spacing → `start` rises in that order; `stop` high 10 cycles after start[1]; `fired`=4'hF, `timed_out`=0, `start[3]` never high.
- **Glitch:** `mic_n[1]` low for 2 cycles while ARMED → no `hit`, state stays ARMED; a 3-cycle low → `start[1]` high 5 cycles after the first sampled low.
- **Timeout:** only mic 0 fires → DONE after exactly 100 RUN cycles; `fired`=4'h1, `timed_out`=1, `start`=0 from that cycle.
- **Simultaneous hits:** mics 0 and 3 in the same cycle → both `fired` bits set; a final hit coinciding with the timeout cycle → `timed_out`=0.
- **abort/clr:** `abort` in RUN → DONE, `timed_out`=1; `clr` asserted mid-RUN → all outputs 0 asynchronously, IDLE, and `arm` still required to restart.
- **Re-arm:** `arm` in DONE → one-cycle `ctr_clear`, `fired`=0, `stop` low, ARMED; `arm` while RUN → ignored.

Source files
------------

// File: rtl/target_pkg.sv
// Shared types and default sizing for the target arming sequencer.
package target_pkg;
    typedef enum logic [2:0] {IDLE, CLEAR, ARMED, RUN, DONE} arm_state_t;

    localparam int N_CH_DEF     = 4;
    localparam int SYNC_DEF     = 2;
    localparam int FILT_LEN_DEF = 3;
    localparam int TIMEOUT_DEF  = 65535;
endpackage

// File: rtl/target_arm_ctrl_mic_filter.sv
// Per-microphone synchroniser and run-length glitch filter.
module mic_filter
    import target_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_DEF,
    parameter int FILT_LEN    = FILT_LEN_DEF
) (
    input  logic clk,
    input  logic clr,
    input  logic mic_n,
    output logic hit
);
    localparam int CW = $clog2(FILT_LEN + 1);
    localparam logic [CW-1:0] RUN_MAX = CW'(FILT_LEN);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          run_q, run_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], ~mic_n};
        run_d  = run_q;
        if (!sync_q[SYNC_STAGES-1]) begin
            run_d = '0;
        end else if (run_q != RUN_MAX) begin
            run_d = run_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sync_q <= '0;
            run_q  <= '0;
        end else begin
            sync_q <= sync_d;
            run_q  <= run_d;
        end
    end

    assign hit = (run_q == RUN_MAX);
endmodule

// File: rtl/target_arm_ctrl.sv
// Arming/trigger sequencer: filters mic inputs, drives counter start/stop/clear
// and closes a shot on all-fired, timeout or abort.
module target_arm_ctrl
    import target_pkg::*;
#(
    parameter int N_CH        = N_CH_DEF,
    parameter int SYNC_STAGES = SYNC_DEF,
    parameter int FILT_LEN    = FILT_LEN_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            arm,
    input  logic            abort,
    input  logic [N_CH-1:0] mic_n,
    output logic [N_CH-1:0] start,
    output logic            stop,
    output logic            ctr_clear,
    output logic            busy,
    output logic            done,
    output logic [N_CH-1:0] fired,
    output logic            timed_out
);
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    logic [N_CH-1:0] hit;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        mic_filter #(
            .SYNC_STAGES(SYNC_STAGES),
            .FILT_LEN   (FILT_LEN)
        ) u_filt (
            .clk  (clk),
            .clr  (clr),
            .mic_n(mic_n[i]),
            .hit  (hit[i])
        );
    end

    arm_state_t      state_q, state_d;
    logic [N_CH-1:0] fired_q, fired_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            timed_out_q, timed_out_d;
    logic [N_CH-1:0] start_q, start_d;
    logic            stop_q, stop_d;
    logic            ctr_clear_q, ctr_clear_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    always_comb begin
        state_d     = state_q;
        fired_d     = fired_q;
        tmo_d       = tmo_q;
        timed_out_d = timed_out_q;
        case (state_q)
            IDLE, DONE: begin
                if (arm) begin
                    state_d     = CLEAR;
                    fired_d     = '0;
                    tmo_d       = '0;
                    timed_out_d = 1'b0;
                end
            end
            CLEAR: begin
                fired_d     = '0;
                tmo_d       = '0;
                timed_out_d = 1'b0;
                if (abort) begin
                    state_d     = DONE;
                    timed_out_d = 1'b1;
                end else begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (abort) begin
                    state_d     = DONE;
                    timed_out_d = 1'b1;
                end else if (|hit) begin
                    fired_d = fired_q | hit;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d     = DONE;
                    timed_out_d = 1'b1;
                end else begin
                    fired_d = fired_q | hit;
                    // All-fired is tested first so a last arrival on the timeout cycle still counts.
                    if (&fired_d) begin
                        state_d     = DONE;
                        timed_out_d = 1'b0;
                    end else if (tmo_q == TMO_LAST) begin
                        state_d     = DONE;
                        timed_out_d = 1'b1;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs follow the next state so they are registered yet aligned with it.
        start_d     = (state_d == RUN) ? fired_d : '0;
        stop_d      = (state_d == DONE);
        ctr_clear_d = (state_d == CLEAR);
        busy_d      = (state_d == CLEAR) || (state_d == ARMED) || (state_d == RUN);
        done_d      = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q     <= IDLE;
            fired_q     <= '0;
            tmo_q       <= '0;
            timed_out_q <= 1'b0;
            start_q     <= '0;
            stop_q      <= 1'b0;
            ctr_clear_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            fired_q     <= fired_d;
            tmo_q       <= tmo_d;
            timed_out_q <= timed_out_d;
            start_q     <= start_d;
            stop_q      <= stop_d;
            ctr_clear_q <= ctr_clear_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign start     = start_q;
    assign stop      = stop_q;
    assign ctr_clear = ctr_clear_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign fired     = fired_q;
    assign timed_out = timed_out_q;
endmodule

// File: tb/tb_target_arm_ctrl.sv
// Directed bench for target_arm_ctrl with N_CH=4, SYNC_STAGES=2, FILT_LEN=3, TIMEOUT_CYC=100.
module tb_target_arm_ctrl;
    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       arm = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] mic_n = 4'hF;
    logic [3:0] start;
    logic       stop;
    logic       ctr_clear;
    logic       busy;
    logic       done;
    logic [3:0] fired;
    logic       timed_out;

    int total = 0;
    int bad = 0;
    logic [3:0] start_or = 4'h0;

    target_arm_ctrl #(
        .N_CH       (4),
        .SYNC_STAGES(2),
        .FILT_LEN   (3),
        .TIMEOUT_CYC(100)
    ) u_dut (
        .clk      (clk),
        .clr      (clr),
        .arm      (arm),
        .abort    (abort),
        .mic_n    (mic_n),
        .start    (start),
        .stop     (stop),
        .ctr_clear(ctr_clear),
        .busy     (busy),
        .done     (done),
        .fired    (fired),
        .timed_out(timed_out)
    );

    always #5 clk = ~clk;

    always @(negedge clk) start_or <= start_or | start;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_start"}, 32'(start), 32'h0);
        check({tag, "_stop"}, 32'(stop), 32'h0);
        check({tag, "_clear"}, 32'(ctr_clear), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_done"}, 32'(done), 32'h0);
        check({tag, "_fired"}, 32'(fired), 32'h0);
        check({tag, "_tmo"}, 32'(timed_out), 32'h0);
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    initial begin
        // Reset
        #2 clr = 1'b1;
        repeat (3) tick();
        check_all_zero("reset");
        clr = 1'b0;
        tick();
        check("idle_busy", 32'(busy), 32'h0);

        // Normal shot: mics 0,2,1,3 at 10-cycle spacing
        do_arm();
        check("arm_clear", 32'(ctr_clear), 32'h1);
        check("arm_busy", 32'(busy), 32'h1);
        check("arm_fired0", 32'(fired), 32'h0);
        tick();
        check("armed_clear_low", 32'(ctr_clear), 32'h0);
        check("armed_busy", 32'(busy), 32'h1);
        start_or = 4'h0;
        mic_n = 4'b1110;
        repeat (5) tick();
        check("n_start0_pre", 32'(start), 32'h0);
        tick();
        check("n_start0", 32'(start), 32'h1);
        repeat (4) tick();
        mic_n = 4'b1010;
        repeat (5) tick();
        check("n_start2_pre", 32'(start), 32'h1);
        tick();
        check("n_start2", 32'(start), 32'h5);
        repeat (4) tick();
        mic_n = 4'b1000;
        repeat (6) tick();
        check("n_start1", 32'(start), 32'h7);
        repeat (4) tick();
        mic_n = 4'b0000;
        repeat (5) tick();
        check("n_stop_pre", 32'(stop), 32'h0);
        check("n_start_pre", 32'(start), 32'h7);
        tick();
        check("n_stop", 32'(stop), 32'h1);
        check("n_done", 32'(done), 32'h1);
        check("n_busy", 32'(busy), 32'h0);
        check("n_start_off", 32'(start), 32'h0);
        check("n_fired", 32'(fired), 32'hF);
        check("n_tmo", 32'(timed_out), 32'h0);
        check("n_start3_never", 32'(start_or), 32'h7);
        mic_n = 4'hF;
        repeat (4) tick();
        check("n_done_hold", 32'(done), 32'h1);

        // Re-arm from DONE
        do_arm();
        check("re_clear", 32'(ctr_clear), 32'h1);
        check("re_fired", 32'(fired), 32'h0);
        check("re_stop", 32'(stop), 32'h0);
        check("re_done", 32'(done), 32'h0);
        tick();
        check("re_clear_once", 32'(ctr_clear), 32'h0);
        check("re_armed", 32'(busy), 32'h1);

        // Glitch: 2-cycle low rejected, 3-cycle low accepted
        mic_n = 4'b1101;
        repeat (2) tick();
        mic_n = 4'hF;
        repeat (8) tick();
        check("g_short_start", 32'(start), 32'h0);
        check("g_short_fired", 32'(fired), 32'h0);
        check("g_short_busy", 32'(busy), 32'h1);
        mic_n = 4'b1101;
        repeat (3) tick();
        mic_n = 4'hF;
        repeat (2) tick();
        check("g_long_pre", 32'(start), 32'h0);
        tick();
        check("g_long_start", 32'(start), 32'h2);

        // arm ignored in RUN, then abort
        do_arm();
        check("run_arm_clear", 32'(ctr_clear), 32'h0);
        check("run_arm_start", 32'(start), 32'h2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_done", 32'(done), 32'h1);
        check("ab_stop", 32'(stop), 32'h1);
        check("ab_start", 32'(start), 32'h0);
        check("ab_tmo", 32'(timed_out), 32'h1);
        check("ab_fired", 32'(fired), 32'h2);
        repeat (4) tick();

        // Timeout with only mic 0
        do_arm();
        tick();
        mic_n = 4'b1110;
        repeat (6) tick();
        check("t_start", 32'(start), 32'h1);
        repeat (99) tick();
        check("t_pre_done", 32'(done), 32'h0);
        check("t_pre_start", 32'(start), 32'h1);
        tick();
        check("t_done", 32'(done), 32'h1);
        check("t_stop", 32'(stop), 32'h1);
        check("t_start_off", 32'(start), 32'h0);
        check("t_fired", 32'(fired), 32'h1);
        check("t_tmo", 32'(timed_out), 32'h1);
        mic_n = 4'hF;
        repeat (4) tick();

        // clr mid-RUN
        do_arm();
        tick();
        mic_n = 4'b1110;
        repeat (6) tick();
        check("c_run_start", 32'(start), 32'h1);
        repeat (3) tick();
        clr = 1'b1;
        #2;
        check_all_zero("c_async");
        repeat (2) tick();
        clr = 1'b0;
        repeat (8) tick();
        check("c_idle_busy", 32'(busy), 32'h0);
        check("c_idle_start", 32'(start), 32'h0);
        check("c_idle_done", 32'(done), 32'h0);
        do_arm();
        check("c_rearm_clear", 32'(ctr_clear), 32'h1);
        tick();
        tick();
        check("c_rearm_start", 32'(start), 32'h1);
        check("c_rearm_fired", 32'(fired), 32'h1);
        mic_n = 4'hF;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("c_abort_tmo", 32'(timed_out), 32'h1);
        repeat (4) tick();

        // Simultaneous hits; final hit on the timeout cycle
        do_arm();
        tick();
        mic_n = 4'b0110;
        repeat (6) tick();
        check("s_start", 32'(start), 32'h9);
        check("s_fired", 32'(fired), 32'h9);
        repeat (94) tick();
        mic_n = 4'b0000;
        repeat (5) tick();
        check("s_pre_done", 32'(done), 32'h0);
        check("s_pre_start", 32'(start), 32'h9);
        tick();
        check("s_done", 32'(done), 32'h1);
        check("s_fired_all", 32'(fired), 32'hF);
        check("s_tmo", 32'(timed_out), 32'h0);
        mic_n = 4'hF;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
